// File: rtl/missionary_cannibal_checker_if.sv
// Sample/status bundle between the puzzle solver and its rule checker.
// The solver side (master) drives the per-cycle left-bank sample and reads
// the checker status; the checker side (slave) does the reverse.
interface missionary_cannibal_checker_if #(
  parameter int COUNT_W = 8
);
  logic               valid;
  logic [1:0]         missionary_in;
  logic [1:0]         cannibal_in;
  logic               boat_side;
  logic [COUNT_W-1:0] move_count;
  logic               move_ok;
  logic               solved;
  logic               error;
  logic [2:0]         error_code;

  modport master (
    output valid, missionary_in, cannibal_in,
    input  boat_side, move_count, move_ok, solved, error, error_code
  );

  modport slave (
    input  valid, missionary_in, cannibal_in,
    output boat_side, move_count, move_ok, solved, error, error_code
  );
endinterface

// File: rtl/missionary_cannibal_checker.sv
// Rule monitor for the missionaries-and-cannibals solver.
// Watches the left-bank (missionary, cannibal) count stream, tracks which bank
// the boat is on, counts accepted moves and latches either puzzle completion
// or the first rule violation together with a code.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the first sample, which must be the (3,3) start
// RUN   | puzzle in progress, every sample is checked as one crossing
// DONE  | (0,0) reached with the boat right; only a (3,3) restart is seen
// ERROR | a violation was latched; everything holds until reset
module missionary_cannibal_checker #(
  parameter int MAX_MOVES = 15,
  parameter int COUNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  missionary_cannibal_checker_if.slave  chk
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DONE  = 3'd2,
    ERROR = 3'd3
  } state_t;

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_BAD_START = 3'd1;
  localparam logic [2:0] CODE_CAPACITY  = 3'd2;
  localparam logic [2:0] CODE_DIRECTION = 3'd3;
  localparam logic [2:0] CODE_UNSAFE    = 3'd4;
  localparam logic [2:0] CODE_TIMEOUT   = 3'd5;

  localparam logic [COUNT_W-1:0] COUNT_SAT  = '1;
  localparam logic [COUNT_W-1:0] MOVE_LIMIT = COUNT_W'(MAX_MOVES);

  state_t             state;
  logic [1:0]         prev_m;
  logic [1:0]         prev_c;
  logic               boat_q;
  logic [COUNT_W-1:0] count_q;
  logic               move_ok_q;
  logic               solved_q;
  logic               error_q;
  logic [2:0]         code_q;

  logic [1:0]         sample_m;
  logic [1:0]         sample_c;
  logic               at_start;
  logic               at_goal;
  logic signed [2:0]  m_s;
  logic signed [2:0]  c_s;
  logic signed [2:0]  pm_s;
  logic signed [2:0]  pc_s;
  logic signed [2:0]  dm;
  logic signed [2:0]  dc;
  logic signed [3:0]  carried;
  logic [1:0]         right_m;
  logic [1:0]         right_c;
  logic               dir_err;
  logic               cap_err;
  logic               unsafe_err;
  logic [2:0]         rule_code;
  logic [COUNT_W-1:0] count_inc;

  assign sample_m = chk.missionary_in;
  assign sample_c = chk.cannibal_in;
  assign at_start = (sample_m == 2'd3) && (sample_c == 2'd3);
  assign at_goal  = (sample_m == 2'd0) && (sample_c == 2'd0);

  // Evaluate the incoming sample as one boat crossing from the bank the boat is on.
  always_comb begin
    m_s  = signed'({1'b0, sample_m});
    c_s  = signed'({1'b0, sample_c});
    pm_s = signed'({1'b0, prev_m});
    pc_s = signed'({1'b0, prev_c});

    // dm/dc are the people carried by the boat; they must leave the boat's bank.
    if (!boat_q) begin
      dm = pm_s - m_s;
      dc = pc_s - c_s;
    end else begin
      dm = m_s - pm_s;
      dc = c_s - pc_s;
    end

    // Widened by one bit so a load of up to 6 cannot wrap negative.
    carried = {dm[2], dm} + {dc[2], dc};

    right_m = 2'd3 - sample_m;
    right_c = 2'd3 - sample_c;

    dir_err    = dm[2] || dc[2];
    cap_err    = (carried == 4'sd0) || (carried > 4'sd2);
    unsafe_err = ((sample_m != 2'd0) && (sample_m < sample_c)) ||
                 ((right_m != 2'd0) && (right_m < right_c));

    if (dir_err)         rule_code = CODE_DIRECTION;
    else if (cap_err)    rule_code = CODE_CAPACITY;
    else if (unsafe_err) rule_code = CODE_UNSAFE;
    else                 rule_code = CODE_NONE;

    count_inc = (count_q == COUNT_SAT) ? count_q : count_q + 1'b1;
  end

  // Puzzle-tracking FSM; every status output is a register written here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev_m    <= 2'd3;
      prev_c    <= 2'd3;
      boat_q    <= 1'b0;
      count_q   <= '0;
      move_ok_q <= 1'b0;
      solved_q  <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= CODE_NONE;
    end else begin
      move_ok_q <= 1'b0;
      case (state)
        IDLE: begin
          if (chk.valid) begin
            if (at_start) begin
              state   <= RUN;
              boat_q  <= 1'b0;
              count_q <= '0;
              prev_m  <= 2'd3;
              prev_c  <= 2'd3;
            end else begin
              state   <= ERROR;
              error_q <= 1'b1;
              code_q  <= CODE_BAD_START;
            end
          end
        end

        RUN: begin
          if (chk.valid) begin
            if (rule_code != CODE_NONE) begin
              state   <= ERROR;
              error_q <= 1'b1;
              code_q  <= rule_code;
            end else begin
              prev_m    <= sample_m;
              prev_c    <= sample_c;
              boat_q    <= ~boat_q;
              count_q   <= count_inc;
              move_ok_q <= 1'b1;
              // The boat ends on the right exactly when it was on the left before this move.
              if (at_goal && !boat_q) begin
                state    <= DONE;
                solved_q <= 1'b1;
              end else if (count_inc == MOVE_LIMIT) begin
                state   <= ERROR;
                error_q <= 1'b1;
                code_q  <= CODE_TIMEOUT;
              end
            end
          end
        end

        DONE: begin
          if (chk.valid && at_start) begin
            state    <= RUN;
            solved_q <= 1'b0;
            count_q  <= '0;
            boat_q   <= 1'b0;
            prev_m   <= 2'd3;
            prev_c   <= 2'd3;
          end
        end

        ERROR: begin
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign chk.boat_side  = boat_q;
  assign chk.move_count = count_q;
  assign chk.move_ok    = move_ok_q;
  assign chk.solved     = solved_q;
  assign chk.error      = error_q;
  assign chk.error_code = code_q;

endmodule

// File: tb/tb_missionary_cannibal_checker.sv
// Bench for the river-crossing rule checker: a directed vector table, a few
// hand-written multi-cycle sequences (timeout, async reset with the clock
// stopped) and a randomized run compared against a rule-level model.
module tb_missionary_cannibal_checker;

  localparam int COUNT_W = 8;
  localparam int MAX0    = 15;
  localparam int MAX1    = 4;

  logic clk;
  logic reset;
  bit   clk_run;

  missionary_cannibal_checker_if #(.COUNT_W(COUNT_W)) bus0 ();
  missionary_cannibal_checker_if #(.COUNT_W(COUNT_W)) bus1 ();

  missionary_cannibal_checker #(.MAX_MOVES(MAX0), .COUNT_W(COUNT_W)) dut0 (
    .clk   (clk),
    .reset (reset),
    .chk   (bus0.slave)
  );

  missionary_cannibal_checker #(.MAX_MOVES(MAX1), .COUNT_W(COUNT_W)) dut1 (
    .clk   (clk),
    .reset (reset),
    .chk   (bus1.slave)
  );

  // Gated free-running clock so the bench can freeze clk for the async-reset check.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- rule-level reference model ----------------
  int mdl_phase;   // 0 waiting for start, 1 playing, 2 finished, 3 failed
  int mdl_pm, mdl_pc, mdl_boat, mdl_cnt, mdl_ok, mdl_solved, mdl_err, mdl_code;

  function automatic int rule_of(int pm, int pc, int boat, int m, int c);
    int moved_m, moved_c;
    int bank_m[2];
    int bank_c[2];
    moved_m = (boat == 0) ? pm - m : m - pm;
    moved_c = (boat == 0) ? pc - c : c - pc;
    if (moved_m < 0 || moved_c < 0) return 3;
    if (moved_m + moved_c == 0 || moved_m + moved_c > 2) return 2;
    bank_m[0] = m;     bank_c[0] = c;
    bank_m[1] = 3 - m; bank_c[1] = 3 - c;
    for (int b = 0; b < 2; b++)
      if (bank_m[b] > 0 && bank_m[b] < bank_c[b]) return 4;
    return 0;
  endfunction

  function automatic void mdl_reset();
    mdl_phase = 0; mdl_pm = 3; mdl_pc = 3; mdl_boat = 0; mdl_cnt = 0;
    mdl_ok = 0; mdl_solved = 0; mdl_err = 0; mdl_code = 0;
  endfunction

  function automatic void mdl_step(int v, int m, int c);
    int r;
    mdl_ok = 0;
    if (v == 0) return;
    if (mdl_phase == 0) begin
      if (m == 3 && c == 3) begin
        mdl_phase = 1; mdl_boat = 0; mdl_cnt = 0; mdl_pm = 3; mdl_pc = 3;
      end else begin
        mdl_phase = 3; mdl_err = 1; mdl_code = 1;
      end
    end else if (mdl_phase == 1) begin
      r = rule_of(mdl_pm, mdl_pc, mdl_boat, m, c);
      if (r != 0) begin
        mdl_phase = 3; mdl_err = 1; mdl_code = r;
      end else begin
        mdl_pm = m; mdl_pc = c; mdl_boat = 1 - mdl_boat;
        mdl_cnt = (mdl_cnt < 255) ? mdl_cnt + 1 : 255;
        mdl_ok = 1;
        if (m == 0 && c == 0 && mdl_boat == 1) begin
          mdl_phase = 2; mdl_solved = 1;
        end else if (mdl_cnt == MAX0) begin
          mdl_phase = 3; mdl_err = 1; mdl_code = 5;
        end
      end
    end else if (mdl_phase == 2) begin
      if (m == 3 && c == 3) begin
        mdl_phase = 1; mdl_solved = 0; mdl_cnt = 0; mdl_boat = 0; mdl_pm = 3; mdl_pc = 3;
      end
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst;
    bit valid;
    int m, c;
    int boat, cnt, ok, solved, err, code;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit v, int m, int c, int boat, int cnt,
                              int ok, int solved, int err, int code);
    vec_t e;
    e.rst = rst; e.valid = v; e.m = m; e.c = c;
    e.boat = boat; e.cnt = cnt; e.ok = ok; e.solved = solved; e.err = err; e.code = code;
    tbl.push_back(e);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    mdl_reset();
  endtask

  task automatic sample0(input bit v, input int m, input int c);
    bus0.valid = v;
    bus0.missionary_in = 2'(m);
    bus0.cannibal_in = 2'(c);
    @(posedge clk);
    #1;
    bus0.valid = 1'b0;
  endtask

  task automatic sample1(input bit v, input int m, input int c);
    bus1.valid = v;
    bus1.missionary_in = 2'(m);
    bus1.cannibal_in = 2'(c);
    @(posedge clk);
    #1;
    bus1.valid = 1'b0;
  endtask

  task automatic check_dut0(input string tag, input int boat, input int cnt, input int ok,
                            input int solved, input int err, input int code);
    chk({tag, ".boat_side"},  bus0.boat_side,  boat);
    chk({tag, ".move_count"}, bus0.move_count, cnt);
    chk({tag, ".move_ok"},    bus0.move_ok,    ok);
    chk({tag, ".solved"},     bus0.solved,     solved);
    chk({tag, ".error"},      bus0.error,      err);
    chk({tag, ".error_code"}, bus0.error_code, code);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ok_pulses;
    int m, c, v;
    int cand_m[$];
    int cand_c[$];
    int pick;

    clk_run = 1'b1;
    reset = 1'b1;
    bus0.valid = 1'b0; bus0.missionary_in = 2'd0; bus0.cannibal_in = 2'd0;
    bus1.valid = 1'b0; bus1.missionary_in = 2'd0; bus1.cannibal_in = 2'd0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    //   rst v  m  c  boat cnt ok sol err code
    // optimal 11-move solution, then DONE behaviour
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 3, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 1, 1,  1, 1, 0, 0, 0);
    add(0, 1, 3, 2, 0,  2, 1, 0, 0, 0);
    add(0, 1, 3, 0, 1,  3, 1, 0, 0, 0);
    add(0, 1, 3, 1, 0,  4, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1,  5, 1, 0, 0, 0);
    add(0, 1, 2, 2, 0,  6, 1, 0, 0, 0);
    add(0, 1, 0, 2, 1,  7, 1, 0, 0, 0);
    add(0, 1, 0, 3, 0,  8, 1, 0, 0, 0);
    add(0, 1, 0, 1, 1,  9, 1, 0, 0, 0);
    add(0, 1, 0, 2, 0, 10, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 11, 1, 1, 0, 0);
    add(0, 0, 3, 3, 1, 11, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 11, 0, 1, 0, 0);
    add(0, 1, 3, 3, 0,  0, 0, 0, 0, 0);
    // gap mid-run, then a direction violation with the boat on the right
    add(0, 1, 3, 1, 1,  1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 0, 0, 0, 0);
    add(0, 1, 3, 0, 1,  1, 0, 0, 1, 3);
    add(0, 1, 3, 3, 1,  1, 0, 0, 1, 3);
    // bad start
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 1, 0,  0, 0, 0, 1, 1);
    // capacity: three carried
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 3, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 0, 0,  0, 0, 0, 1, 2);
    // unsafe left bank
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 3, 0,  0, 0, 0, 0, 0);
    add(0, 1, 2, 3, 0,  0, 0, 0, 1, 4);
    // repeated sample is an empty boat
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 3, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 3, 0,  0, 0, 0, 1, 2);
    // capacity outranks unsafe: (3,3)->(1,2) carries 3 and leaves left unsafe
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 3, 0,  0, 0, 0, 0, 0);
    add(0, 1, 1, 2, 0,  0, 0, 0, 1, 2);
    // direction outranks capacity: boat right, m drops by 1 while c rises by 2
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 3, 0,  0, 0, 0, 0, 0);
    add(0, 1, 3, 1, 1,  1, 1, 0, 0, 0);
    add(0, 1, 2, 3, 1,  1, 0, 0, 1, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      else sample0(tbl[i].valid, tbl[i].m, tbl[i].c);
      check_dut0($sformatf("vec%0d", i), tbl[i].boat, tbl[i].cnt, tbl[i].ok,
                 tbl[i].solved, tbl[i].err, tbl[i].code);
    end

    // Timeout on the MAX_MOVES=4 instance: four legal moves, the fourth trips it.
    do_reset();
    ok_pulses = 0;
    sample1(1, 3, 3);
    ok_pulses += int'(bus1.move_ok);
    sample1(1, 3, 1);
    ok_pulses += int'(bus1.move_ok);
    sample1(1, 3, 3);
    ok_pulses += int'(bus1.move_ok);
    sample1(1, 3, 1);
    ok_pulses += int'(bus1.move_ok);
    chk("timeout.pre_count", bus1.move_count, 3);
    chk("timeout.pre_error", bus1.error, 0);
    sample1(1, 3, 3);
    ok_pulses += int'(bus1.move_ok);
    chk("timeout.ok_pulses", ok_pulses, 4);
    chk("timeout.error", bus1.error, 1);
    chk("timeout.error_code", bus1.error_code, 5);
    chk("timeout.move_count", bus1.move_count, 4);
    chk("timeout.boat_side", bus1.boat_side, 0);
    sample1(1, 3, 1);
    chk("timeout.hold_ok", bus1.move_ok, 0);
    chk("timeout.hold_count", bus1.move_count, 4);

    // Async reset with the clock frozen mid-run.
    do_reset();
    sample0(1, 3, 3);
    sample0(1, 3, 1);
    sample0(1, 3, 2);
    check_dut0("midrun", 0, 2, 1, 0, 0, 0);
    @(negedge clk);
    clk_run = 1'b0;
    #12;
    chk("frozen.move_count", bus0.move_count, 2);
    reset = 1'b1;
    #1;
    check_dut0("async_reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    mdl_reset();
    sample0(1, 3, 3);
    check_dut0("restart", 0, 0, 0, 0, 0, 0);
    sample0(1, 2, 2);
    check_dut0("restart_move", 1, 1, 1, 0, 0, 0);

    // Randomized run against the rule-level model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ((mdl_phase >= 2 && $urandom_range(0, 5) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
        check_dut0($sformatf("rnd%0d.reset", n), 0, 0, 0, 0, 0, 0);
      end else begin
        v = ($urandom_range(0, 3) != 0) ? 1 : 0;
        m = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        if ((mdl_phase == 0 || mdl_phase == 2) && $urandom_range(0, 4) != 0) begin
          m = 3; c = 3;
        end else if (mdl_phase == 1 && $urandom_range(0, 9) < 8) begin
          cand_m.delete();
          cand_c.delete();
          for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
              if (rule_of(mdl_pm, mdl_pc, mdl_boat, a, b) == 0) begin
                cand_m.push_back(a);
                cand_c.push_back(b);
              end
          if (cand_m.size() > 0) begin
            pick = $urandom_range(0, cand_m.size() - 1);
            m = cand_m[pick];
            c = cand_c[pick];
          end
        end
        sample0(v[0], m, c);
        mdl_step(v, m, c);
        check_dut0($sformatf("rnd%0d", n), mdl_boat, mdl_cnt, mdl_ok,
                   mdl_solved, mdl_err, mdl_code);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
